// File: rtl/dma_pkg.sv
// Shared types and constants for the two-channel fly-by DMA controller.
package dma_pkg;

  typedef enum logic [2:0] {IDLE, REQ, S1, S2, S3} state_e;

  typedef logic ch_t;

  localparam logic DIR_IO2MEM = 1'b0;
  localparam logic DIR_MEM2IO = 1'b1;

  // Strobe vector order: {IOR, IOW, MEMR, MEMW}
  localparam logic [3:0] STRB_IO2MEM = 4'b1001;
  localparam logic [3:0] STRB_MEM2IO = 4'b0110;

  function automatic logic [1:0] ch_onehot(input ch_t c);
    return c ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dma_if.sv
// CPU configuration port plus the shared-bus handshake and strobe signals of the DMA.
interface dma_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
);
  import dma_pkg::*;

  logic              cfg_we;
  ch_t               cfg_ch;
  logic [ADDR_W-1:0] cfg_dram_addr;
  logic [ADDR_W-1:0] cfg_io_addr;
  logic [CNT_W-1:0]  cfg_count;
  logic              cfg_dir;
  logic [1:0]        clr_tc;
  logic [1:0]        DREQ;
  logic              HLDA;

  logic              HRQ;
  logic [1:0]        DACK;
  logic              IOR, IOW, MEMR, MEMW;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] io_addr;
  logic              EOP_n;
  logic [1:0]        busy;
  logic [1:0]        tc;

  modport slave (
    input  cfg_we, cfg_ch, cfg_dram_addr, cfg_io_addr, cfg_count, cfg_dir,
           clr_tc, DREQ, HLDA,
    output HRQ, DACK, IOR, IOW, MEMR, MEMW, mem_addr, io_addr, EOP_n, busy, tc
  );

  modport master (
    output cfg_we, cfg_ch, cfg_dram_addr, cfg_io_addr, cfg_count, cfg_dir,
           clr_tc, DREQ, HLDA,
    input  HRQ, DACK, IOR, IOW, MEMR, MEMW, mem_addr, io_addr, EOP_n, busy, tc
  );

endinterface

// File: rtl/dma_channel_regs.sv
// Per-channel address/count/direction state with busy and sticky terminal-count flags.
module dma_channel_regs
  import dma_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] dram_i,
  input  logic [ADDR_W-1:0] io_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              dir_i,
  input  logic              step_i,
  input  logic              clr_tc_i,
  output logic [ADDR_W-1:0] dram_addr_o,
  output logic [ADDR_W-1:0] io_addr_o,
  output logic              dir_o,
  output logic              busy_o,
  output logic              tc_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] dram_q, dram_d, io_q, io_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              dir_q, dir_d, busy_q, busy_d, tc_q, tc_d;

  assign last_o = (count_q == CNT_W'(1));

  always_comb begin
    dram_d  = dram_q;
    io_d    = io_q;
    count_d = count_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    if (load_i) begin
      dram_d  = dram_i;
      io_d    = io_i;
      count_d = count_i;
      dir_d   = dir_i;
      busy_d  = (count_i != '0);
    end else if (step_i) begin
      // Addresses wrap naturally at 2^ADDR_W
      dram_d  = dram_q + ADDR_W'(1);
      io_d    = io_q + ADDR_W'(1);
      count_d = count_q - CNT_W'(1);
      if (last_o) busy_d = 1'b0;
    end
    // A terminal count landing with a clear keeps the flag set
    tc_d = tc_q;
    if (step_i && last_o) tc_d = 1'b1;
    else if (clr_tc_i)    tc_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dram_q  <= '0;
      io_q    <= '0;
      count_q <= '0;
      dir_q   <= DIR_IO2MEM;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      dram_q  <= dram_d;
      io_q    <= io_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
    end
  end

  assign dram_addr_o = dram_q;
  assign io_addr_o   = io_q;
  assign dir_o       = dir_q;
  assign busy_o      = busy_q;
  assign tc_o        = tc_q;

endmodule

// File: rtl/dma_controller.sv
// Two-channel fly-by DMA: fixed-priority arbiter and bus sequencer with registered outputs.
module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 10,
  parameter int STROBE_CYC = 1
) (
  input logic  CLK,
  input logic  RST,
  dma_if.slave bus
);

  localparam int SCW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(STROBE_CYC - 1);

  state_e            state_q;
  ch_t               ch_q;
  logic              hrq_q, eop_n_q;
  logic [1:0]        dack_q;
  logic [3:0]        strb_q;
  logic [ADDR_W-1:0] mem_addr_q, io_addr_q;
  logic [SCW-1:0]    scnt_q;

  logic [1:0][ADDR_W-1:0] ch_dram, ch_io;
  logic [1:0]             ch_dir, ch_busy, ch_tc, ch_last, ch_load, ch_step;
  logic [1:0]             req;
  logic                   strobe_last;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    dma_channel_regs #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_regs (
      .clk         (CLK),
      .rst         (RST),
      .load_i      (ch_load[c]),
      .dram_i      (bus.cfg_dram_addr),
      .io_i        (bus.cfg_io_addr),
      .count_i     (bus.cfg_count),
      .dir_i       (bus.cfg_dir),
      .step_i      (ch_step[c]),
      .clr_tc_i    (bus.clr_tc[c]),
      .dram_addr_o (ch_dram[c]),
      .io_addr_o   (ch_io[c]),
      .dir_o       (ch_dir[c]),
      .busy_o      (ch_busy[c]),
      .tc_o        (ch_tc[c]),
      .last_o      (ch_last[c])
    );
  end

  assign req         = ch_busy & bus.DREQ;
  assign strobe_last = (scnt_q == SC_LAST);

  always_comb begin
    ch_load = '0;
    ch_step = '0;
    // Armed channels and the bus owner are locked against reprogramming
    for (int c = 0; c < 2; c++) begin
      ch_load[c] = bus.cfg_we && (bus.cfg_ch == ch_t'(c)) && !ch_busy[c] &&
                   !((state_q != IDLE) && (ch_q == ch_t'(c)));
    end
    ch_step[ch_q] = (state_q == S2) && strobe_last && bus.HLDA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      hrq_q      <= 1'b0;
      dack_q     <= '0;
      strb_q     <= '0;
      mem_addr_q <= '0;
      io_addr_q  <= '0;
      eop_n_q    <= 1'b1;
      scnt_q     <= '0;
    end else begin
      eop_n_q <= 1'b1;
      unique case (state_q)
        IDLE: if (|req) begin
          ch_q    <= ch_t'(!req[0]);
          hrq_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: if (bus.HLDA) begin
          state_q    <= S1;
          dack_q     <= ch_onehot(ch_q);
          mem_addr_q <= ch_dram[ch_q];
          io_addr_q  <= ch_io[ch_q];
        end
        S1: if (!bus.HLDA) begin
          dack_q  <= '0;
          state_q <= REQ;
        end else begin
          state_q <= S2;
          scnt_q  <= '0;
          strb_q  <= (ch_dir[ch_q] == DIR_IO2MEM) ? STRB_IO2MEM : STRB_MEM2IO;
        end
        S2: if (!bus.HLDA) begin
          // Grant lost: drop the word, keep requesting, retry after re-grant
          strb_q  <= '0;
          dack_q  <= '0;
          state_q <= REQ;
        end else if (strobe_last) begin
          strb_q  <= '0;
          eop_n_q <= !ch_last[ch_q];
          state_q <= S3;
        end else begin
          scnt_q <= scnt_q + SCW'(1);
        end
        S3: if (ch_busy[ch_q] && bus.DREQ[ch_q] && bus.HLDA) begin
          state_q    <= S1;
          mem_addr_q <= ch_dram[ch_q];
          io_addr_q  <= ch_io[ch_q];
        end else begin
          state_q <= IDLE;
          hrq_q   <= 1'b0;
          dack_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.HRQ      = hrq_q;
  assign bus.DACK     = dack_q;
  assign bus.IOR      = strb_q[3];
  assign bus.IOW      = strb_q[2];
  assign bus.MEMR     = strb_q[1];
  assign bus.MEMW     = strb_q[0];
  assign bus.mem_addr = mem_addr_q;
  assign bus.io_addr  = io_addr_q;
  assign bus.EOP_n    = eop_n_q;
  assign bus.busy     = ch_busy;
  assign bus.tc       = ch_tc;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench: cycle table for a 3-word burst, then hand sequences for the corner cases.
module tb_dma_controller;
  import dma_pkg::*;

  localparam int AW = 10;
  localparam int CW = 10;

  typedef struct packed {
    logic [1:0]    dreq;
    logic          hlda;
    logic          hrq;
    logic [1:0]    dack;
    logic [3:0]    strb;
    logic [AW-1:0] ma;
    logic [AW-1:0] ia;
    logic          eop_n;
    logic [1:0]    busy;
    logic [1:0]    tc;
  } vec_t;

  localparam logic [31:0] RST_VAL = {1'b0, 2'b00, 4'b0000, 10'h000, 10'h000, 1'b1, 2'b00, 2'b00};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_if #(.ADDR_W(AW), .CNT_W(CW)) ifc();
  dma_controller #(.ADDR_W(AW), .CNT_W(CW), .STROBE_CYC(1)) dut (.CLK(clk), .RST(rst), .bus(ifc));

  int n_chk = 0, n_fail = 0;
  int eop_cnt, n_i2m, n_m2i;
  bit auto_cpu, gap, bad_pair;
  logic [AW-1:0] sa[$], si[$], sd[$], exp_q[$];
  vec_t tbl[12];

  function automatic logic [31:0] outs();
    return {ifc.HRQ, ifc.DACK, ifc.IOR, ifc.IOW, ifc.MEMR, ifc.MEMW,
            ifc.mem_addr, ifc.io_addr, ifc.EOP_n, ifc.busy, ifc.tc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm, input logic [AW-1:0] act[$], input logic [AW-1:0] exp[$]);
    chk({nm, " length"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), act[i], exp[i]);
  endtask

  // One clock; sample just after the edge, log bus activity, model a CPU granting HLDA
  task automatic tick();
    @(posedge clk); #1;
    if (ifc.IOR || ifc.IOW || ifc.MEMR || ifc.MEMW) begin
      sa.push_back(ifc.mem_addr);
      si.push_back(ifc.io_addr);
      sd.push_back(AW'(ifc.DACK));
    end
    if ((ifc.IOR && ifc.IOW) || (ifc.MEMR && ifc.MEMW)) bad_pair = 1;
    if (ifc.IOR || ifc.MEMW) n_i2m++;
    if (ifc.MEMR && ifc.IOW) n_m2i++;
    if (!ifc.EOP_n) eop_cnt++;
    if (eop_cnt == 1 && !ifc.HRQ) gap = 1;
    if (auto_cpu) ifc.HLDA = ifc.HRQ & ifc.EOP_n;
  endtask

  task automatic cfg(input ch_t ch, input logic [AW-1:0] d, input logic [AW-1:0] io,
                     input logic [CW-1:0] n, input logic dir);
    ifc.cfg_ch = ch; ifc.cfg_dram_addr = d; ifc.cfg_io_addr = io;
    ifc.cfg_count = n; ifc.cfg_dir = dir; ifc.cfg_we = 1'b1;
    tick();
    ifc.cfg_we = 1'b0;
  endtask

  task automatic clr(input logic [1:0] m);
    ifc.clr_tc = m;
    tick();
    ifc.clr_tc = 2'b00;
  endtask

  task automatic clear_logs();
    sa.delete(); si.delete(); sd.delete();
    eop_cnt = 0; n_i2m = 0; n_m2i = 0; gap = 0; bad_pair = 0;
  endtask

  task automatic run_until_tc(input string nm, input int ch);
    bit hit = 0;
    for (int i = 0; i < 80 && !hit; i++) begin
      tick();
      hit = ifc.tc[ch];
    end
    chk({nm, " reached tc"}, 32'(hit), 32'd1);
    tick();
    chk({nm, " HRQ low after tc"}, 32'(ifc.HRQ), 32'd0);
    chk({nm, " busy cleared"}, 32'(ifc.busy[ch]), 32'd0);
  endtask

  task automatic wait_strobe(input string nm);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      hit = ifc.IOR || ifc.MEMR;
    end
    chk({nm, " strobe seen"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.cfg_we = 0; ifc.cfg_ch = '0; ifc.cfg_dram_addr = '0; ifc.cfg_io_addr = '0;
    ifc.cfg_count = '0; ifc.cfg_dir = 0; ifc.clr_tc = 0; ifc.DREQ = 0; ifc.HLDA = 0;
    auto_cpu = 0;
    clear_logs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset state", outs(), RST_VAL);

    // Zero count leaves a channel disarmed
    cfg(1'b1, 10'h155, 10'h0AA, 10'd0, 1'b0);
    chk("count0 not armed", 32'(ifc.busy), 32'd0);

    // Test 1: 3-word IO->DRAM burst, HLDA two cycles behind HRQ
    //            dreq   hlda hrq dack   strb     ma      ia     eop  busy   tc
    tbl[0]  = '{2'b01, 0, 1, 2'b00, 4'b0000, 10'h000, 10'h000, 1, 2'b01, 2'b00};
    tbl[1]  = '{2'b01, 0, 1, 2'b00, 4'b0000, 10'h000, 10'h000, 1, 2'b01, 2'b00};
    tbl[2]  = '{2'b01, 1, 1, 2'b01, 4'b0000, 10'h100, 10'h020, 1, 2'b01, 2'b00};
    tbl[3]  = '{2'b01, 1, 1, 2'b01, 4'b1001, 10'h100, 10'h020, 1, 2'b01, 2'b00};
    tbl[4]  = '{2'b01, 1, 1, 2'b01, 4'b0000, 10'h100, 10'h020, 1, 2'b01, 2'b00};
    tbl[5]  = '{2'b01, 1, 1, 2'b01, 4'b0000, 10'h101, 10'h021, 1, 2'b01, 2'b00};
    tbl[6]  = '{2'b01, 1, 1, 2'b01, 4'b1001, 10'h101, 10'h021, 1, 2'b01, 2'b00};
    tbl[7]  = '{2'b01, 1, 1, 2'b01, 4'b0000, 10'h101, 10'h021, 1, 2'b01, 2'b00};
    tbl[8]  = '{2'b01, 1, 1, 2'b01, 4'b0000, 10'h102, 10'h022, 1, 2'b01, 2'b00};
    tbl[9]  = '{2'b01, 1, 1, 2'b01, 4'b1001, 10'h102, 10'h022, 1, 2'b01, 2'b00};
    tbl[10] = '{2'b01, 1, 1, 2'b01, 4'b0000, 10'h102, 10'h022, 0, 2'b00, 2'b01};
    tbl[11] = '{2'b01, 0, 0, 2'b00, 4'b0000, 10'h102, 10'h022, 1, 2'b00, 2'b01};
    cfg(1'b0, 10'h100, 10'h020, 10'd3, DIR_IO2MEM);
    for (int i = 0; i < 12; i++) begin
      ifc.DREQ = tbl[i].dreq;
      ifc.HLDA = tbl[i].hlda;
      tick();
      chk($sformatf("t1 cycle %0d", i), outs(),
          {tbl[i].hrq, tbl[i].dack, tbl[i].strb, tbl[i].ma, tbl[i].ia,
           tbl[i].eop_n, tbl[i].busy, tbl[i].tc});
    end
    ifc.DREQ = 0; ifc.HLDA = 0;

    // Test 2: both channels requesting, ch0 wins and finishes first
    clr(2'b11);
    chk("t2 tc cleared", 32'(ifc.tc), 32'd0);
    cfg(1'b0, 10'h000, 10'h010, 10'd2, DIR_IO2MEM);
    cfg(1'b1, 10'h180, 10'h030, 10'd2, DIR_IO2MEM);
    clear_logs();
    auto_cpu = 1;
    ifc.DREQ = 2'b11;
    run_until_tc("t2", 1);
    exp_q = '{10'h000, 10'h001, 10'h180, 10'h181};
    chk_q("t2 addr", sa, exp_q);
    exp_q = '{10'h001, 10'h001, 10'h002, 10'h002};
    chk_q("t2 dack", sd, exp_q);
    chk("t2 eop pulses", eop_cnt, 2);
    chk("t2 HRQ gap", 32'(gap), 32'd1);
    chk("t2 tc", 32'(ifc.tc), 32'd3);

    // Test 3: DRAM->IO across the address wrap
    ifc.DREQ = 0;
    clr(2'b11);
    chk("t3 tc cleared", 32'(ifc.tc), 32'd0);
    cfg(1'b0, 10'h3FE, 10'h000, 10'd3, DIR_MEM2IO);
    clear_logs();
    ifc.DREQ = 2'b01;
    run_until_tc("t3", 0);
    exp_q = '{10'h3FE, 10'h3FF, 10'h000};
    chk_q("t3 addr", sa, exp_q);
    chk("t3 no IOR/MEMW", n_i2m, 0);
    chk("t3 MEMR+IOW words", n_m2i, 3);
    chk("t3 strobe pairs exclusive", 32'(bad_pair), 32'd0);

    // Test 4: grant lost in S2 of word 2, word retried after re-grant
    ifc.DREQ = 0;
    clr(2'b01);
    cfg(1'b0, 10'h200, 10'h050, 10'd4, DIR_IO2MEM);
    clear_logs();
    ifc.DREQ = 2'b01;
    begin
      bit hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
        tick();
        hit = ifc.IOR && (ifc.mem_addr == 10'h201);
      end
      chk("t4 reached word2", 32'(hit), 32'd1);
    end
    auto_cpu = 0;
    ifc.HLDA = 0;
    tick();
    chk("t4 abort strobes", {ifc.IOR, ifc.IOW, ifc.MEMR, ifc.MEMW}, 4'b0000);
    chk("t4 abort DACK", 32'(ifc.DACK), 32'd0);
    chk("t4 abort HRQ", 32'(ifc.HRQ), 32'd1);
    tick();
    chk("t4 HRQ held", 32'(ifc.HRQ), 32'd1);
    chk("t4 busy kept", 32'(ifc.busy[0]), 32'd1);
    ifc.HLDA = 1;
    auto_cpu = 1;
    run_until_tc("t4", 0);
    exp_q = '{10'h200, 10'h201, 10'h201, 10'h202, 10'h203};
    chk_q("t4 addr", sa, exp_q);
    chk("t4 eop pulses", eop_cnt, 1);

    // Test 5: DREQ drop pauses the burst; locked reprogram ignored, other channel accepted
    ifc.DREQ = 0;
    clr(2'b01);
    cfg(1'b0, 10'h300, 10'h040, 10'd5, DIR_IO2MEM);
    clear_logs();
    ifc.DREQ = 2'b01;
    wait_strobe("t5");
    ifc.DREQ = 2'b00;
    tick();
    tick();
    chk("t5 paused HRQ", 32'(ifc.HRQ), 32'd0);
    chk("t5 paused DACK", 32'(ifc.DACK), 32'd0);
    chk("t5 paused busy", 32'(ifc.busy), 32'd1);
    cfg(1'b0, 10'h000, 10'h000, 10'd1, DIR_MEM2IO);
    cfg(1'b1, 10'h1C0, 10'h060, 10'd2, DIR_IO2MEM);
    chk("t5 ch1 armed", 32'(ifc.busy), 32'd3);
    ifc.DREQ = 2'b01;
    run_until_tc("t5", 0);
    exp_q = '{10'h300, 10'h301, 10'h302, 10'h303, 10'h304};
    chk_q("t5 mem addr", sa, exp_q);
    exp_q = '{10'h040, 10'h041, 10'h042, 10'h043, 10'h044};
    chk_q("t5 io addr", si, exp_q);

    // Test 6: reset in S2 aborts with no EOP
    clear_logs();
    ifc.DREQ = 2'b10;
    wait_strobe("t6");
    rst = 1;
    tick();
    rst = 0;
    chk("t6 reset outputs", outs(), RST_VAL);
    tick();
    chk("t6 stays idle", 32'(ifc.HRQ), 32'd0);
    chk("t6 no eop", eop_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
